rns_writeback: RTL and testbench

RNS_WRITEBACK -- requirements
Module: rns_writeback

---
 rtl/rns_pkg.sv | 17 +
 rtl/rns_mod_reduce.sv | 34 +++
 rtl/rns_writeback.sv | 168 ++++++++++++++++
 tb/tb_rns_writeback.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// ----------------------------------------------------------------------------
// rns_pkg
// Shared definitions for the RNS write-back block: domain width, default
// moduli and the conversion FSM state type.
// ----------------------------------------------------------------------------
package rns_pkg;

    localparam int         DOMAIN_W     = 8;
    localparam logic [7:0] MOD0_DEFAULT = 8'd13;
    localparam logic [7:0] MOD1_DEFAULT = 8'd23;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/rns_mod_reduce.sv
// ----------------------------------------------------------------------------
// rns_mod_reduce
// One step of the shift-subtract residue reducer: appends one input bit to
// the running residue and subtracts the modulus once if the result reaches it.
// Purely combinational; the caller owns the residue register.
//
// Ports:
//   r_in   in  9  current residue (always < MOD)
//   bit_in in  1  next input bit, MSB first
//   r_out  out 9  updated residue (always < MOD)
// ----------------------------------------------------------------------------
module rns_mod_reduce
    import rns_pkg::*;
#(
    parameter logic [DOMAIN_W-1:0] MOD = MOD0_DEFAULT
) (
    input  logic [DOMAIN_W:0] r_in,
    input  logic              bit_in,
    output logic [DOMAIN_W:0] r_out
);

    // One extra bit so the shifted value can never overflow before the compare.
    logic [DOMAIN_W+1:0] shifted;

    always_comb begin
        shifted = {r_in, bit_in};
        // Residue stays below MOD, so 2*r+1 < 2*MOD and one subtraction suffices.
        if (shifted >= (DOMAIN_W + 2)'(MOD))
            r_out = (DOMAIN_W + 1)'(shifted - (DOMAIN_W + 2)'(MOD));
        else
            r_out = shifted[DOMAIN_W:0];
    end

endmodule

// File: rtl/rns_writeback.sv
// ----------------------------------------------------------------------------
// rns_writeback
// Write-back stage for ALU results. Plain results are written to the register
// file one cycle after acceptance. With RNS_FWD_CONV_EN defined, results
// flagged res_to_rns are converted to two 8-bit residues (MOD0, MOD1) over
// eight cycles and written to the RNS file. With RNS_FWD_CONV_EN undefined,
// such requests are written as plain data to the RNS file and the sticky
// err_unsup flag is raised.
//
// Ports:
//   clk        in   1   clock, posedge
//   reset      in   1   asynchronous active-high reset
//   in_valid   in   1   upstream result valid
//   in_ready   out  1   block can accept a result this cycle
//   res_data   in   8   integer result
//   res_addr   in   4   destination address, bit 3 selects the RNS file
//   res_to_rns in   1   convert to residues and write the RNS file
//   flush      in   1   abort in-flight conversion / block acceptance
//   wr_en      out  1   register-file write strobe
//   wr_addr    out  4   register-file write address
//   wr_data    out  16  register-file write data
//   wr_RNS     out  1   selects the RNS register file
//   busy       out  1   conversion in flight
//   err_unsup  out  1   sticky: conversion requested but not built
//
// Configuration macro: RNS_FWD_CONV_EN
// ----------------------------------------------------------------------------
module rns_writeback
    import rns_pkg::*;
#(
    parameter int                  NUM_DOMAINS = 2,   // only 2 is supported
    parameter logic [DOMAIN_W-1:0] MOD0        = MOD0_DEFAULT,
    parameter logic [DOMAIN_W-1:0] MOD1        = MOD1_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DOMAIN_W-1:0]             res_data,
    input  logic [3:0]                      res_addr,
    input  logic                            res_to_rns,
    input  logic                            flush,
    output logic                            wr_en,
    output logic [3:0]                      wr_addr,
    output logic [NUM_DOMAINS*DOMAIN_W-1:0] wr_data,
    output logic                            wr_RNS,
    output logic                            busy,
    output logic                            err_unsup
);

    logic accept;

`ifdef RNS_FWD_CONV_EN

    state_t              state, state_next;
    logic [2:0]          cnt;
    logic [DOMAIN_W:0]   r0, r1, r0_next, r1_next;
    logic [DOMAIN_W-1:0] lat_data;
    logic [2:0]          lat_addr;
    logic                bit_in;

    assign err_unsup = 1'b0;

    always_comb begin
        in_ready = (state == IDLE) && !reset && !flush;
        accept   = in_valid && in_ready;
        busy     = (state == CONV);
        bit_in   = lat_data[3'd7 - cnt];   // MSB first
    end

    rns_mod_reduce #(.MOD(MOD0)) u_red0 (.r_in(r0), .bit_in(bit_in), .r_out(r0_next));
    rns_mod_reduce #(.MOD(MOD1)) u_red1 (.r_in(r1), .bit_in(bit_in), .r_out(r1_next));

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && res_to_rns)      state_next = CONV;
            CONV:    if (flush || cnt == 3'd7)      state_next = IDLE;
            default:                                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            r0       <= '0;
            r1       <= '0;
            lat_data <= '0;
            lat_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_RNS   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
                if (accept) begin
                    if (res_to_rns) begin
                        lat_data <= res_data;
                        lat_addr <= res_addr[2:0];
                        r0       <= '0;
                        r1       <= '0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= res_addr;
                        wr_RNS  <= res_addr[3];
                        wr_data <= {8'h00, res_data};
                    end
                end
            end else if (flush) begin
                cnt <= '0;    // abandon conversion, no write
            end else begin
                cnt <= cnt + 3'd1;
                r0  <= r0_next;
                r1  <= r1_next;
                if (cnt == 3'd7) begin
                    // Last bit: write the freshly reduced residues directly.
                    wr_en   <= 1'b1;
                    wr_addr <= {1'b1, lat_addr};
                    wr_RNS  <= 1'b1;
                    wr_data <= {r1_next[DOMAIN_W-1:0], r0_next[DOMAIN_W-1:0]};
                end
            end
        end
    end

`else

    // Conversion hardware not built: every request is a one-cycle write.
    assign busy = 1'b0;

    always_comb begin
        in_ready = !reset && !flush;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_RNS    <= 1'b0;
            err_unsup <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                wr_en   <= 1'b1;
                wr_addr <= res_addr;
                wr_RNS  <= res_addr[3] | res_to_rns;
                wr_data <= {8'h00, res_data};
                if (res_to_rns) err_unsup <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: tb/tb_rns_writeback.sv
// ----------------------------------------------------------------------------
// tb_rns_writeback
// Self-checking bench for rns_writeback. A transaction-level reference model
// tracks accepted requests and predicts each write (residues by plain modulo
// arithmetic) and the ready/busy/err_unsup flags, cycle by cycle.
// Works with RNS_FWD_CONV_EN defined or undefined.
// ----------------------------------------------------------------------------
module tb_rns_writeback;

`ifdef RNS_FWD_CONV_EN
    localparam bit CONV_EN = 1'b1;
`else
    localparam bit CONV_EN = 1'b0;
`endif
    localparam int M0       = 13;
    localparam int M1       = 23;
    localparam int CONV_LAT = 8;   // edges from acceptance to the write edge

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, res_to_rns, flush;
    logic [7:0]  res_data;
    logic [3:0]  res_addr;
    logic        in_ready, wr_en, wr_RNS, busy, err_unsup;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    always #5 clk = ~clk;

    rns_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_data   (res_data),
        .res_addr   (res_addr),
        .res_to_rns (res_to_rns),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_RNS     (wr_RNS),
        .busy       (busy),
        .err_unsup  (err_unsup)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state
    bit          m_conv;
    int          m_left;
    logic [7:0]  m_data;
    logic [2:0]  m_addr;
    logic [3:0]  last_addr;
    logic [15:0] last_data;
    logic        last_rns;
    bit          m_err;

    task automatic model_reset();
        m_conv    = 1'b0;
        m_left    = 0;
        last_addr = '0;
        last_data = '0;
        last_rns  = 1'b0;
        m_err     = 1'b0;
    endtask

    // Runs one clock cycle: starts and ends at a negedge.
    task automatic drive_cycle(input bit v, input logic [7:0] d, input logic [3:0] a,
                               input bit t, input bit f);
        bit exp_wen;
        in_valid   = v;
        res_data   = d;
        res_addr   = a;
        res_to_rns = t;
        flush      = f;
        #1;
        check("in_ready", in_ready, !m_conv && !f);
        check("busy", busy, m_conv);
        @(posedge clk);
        exp_wen = 1'b0;
        if (m_conv) begin
            if (f) begin
                m_conv = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_conv    = 1'b0;
                    exp_wen   = 1'b1;
                    last_addr = {1'b1, m_addr};
                    last_rns  = 1'b1;
                    last_data = {8'(int'(m_data) % M1), 8'(int'(m_data) % M0)};
                end
            end
        end else if (v && !f) begin
            if (t && CONV_EN) begin
                m_conv = 1'b1;
                m_left = CONV_LAT;
                m_data = d;
                m_addr = a[2:0];
            end else begin
                exp_wen   = 1'b1;
                last_addr = a;
                last_rns  = a[3] | t;
                last_data = {8'h00, d};
                if (t) m_err = 1'b1;
            end
        end
        #1;
        check("wr_en", wr_en, exp_wen);
        check("wr_addr", wr_addr, last_addr);
        check("wr_data", wr_data, last_data);
        check("wr_RNS", wr_RNS, last_rns);
        check("err_unsup", err_unsup, m_err);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_RNS"}, wr_RNS, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_err_unsup"}, err_unsup, 0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        res_data   = '0;
        res_addr   = '0;
        res_to_rns = 1'b0;
        flush      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Plain write
        drive_cycle(1'b1, 8'hA5, 4'h3, 1'b0, 1'b0);
        idle(1);

        // Conversions: 200 -> 0x1005, 255 -> 0x0208, 0 -> 0x0000
        drive_cycle(1'b1, 8'd200, 4'h2, 1'b1, 1'b0);
        idle(10);
        drive_cycle(1'b1, 8'd255, 4'h5, 1'b1, 1'b0);
        idle(10);
        drive_cycle(1'b1, 8'd0, 4'h1, 1'b1, 1'b0);
        idle(10);

        // Flush at counter = 4, then ready again the cycle after
        drive_cycle(1'b1, 8'd77, 4'h6, 1'b1, 1'b0);
        idle(4);
        drive_cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b1);
        idle(10);

        // Flush and in_valid together: no acceptance
        drive_cycle(1'b1, 8'h3C, 4'h4, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h3C, 4'h4, 1'b1, 1'b1);
        idle(2);

        // Four back-to-back plain writes
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 8'(8'h10 + i * 8'h11), 4'(4'h8 + i), 1'b0, 1'b0);
        idle(1);

        // Reset mid-conversion at counter = 5
        drive_cycle(1'b1, 8'd123, 4'h7, 1'b1, 1'b0);
        idle(5);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, 8'($urandom), 4'($urandom),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
